// File: rtl/tmr_voter_seq.sv
// Stateful majority voter for NHARTS redundant OBI requestors with fault isolation and degrade/fail FSM.
// Optional feature macro: TMR_VOTER_ERR_CNT_EN adds per-hart saturating total error counters.
package tmr_voter_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;
endpackage

module tmr_voter_seq
    import tmr_voter_pkg::*;
#(
    parameter int unsigned NHARTS        = 3,
    parameter int unsigned ERR_THRESHOLD = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  obi_req_t                  core_instr_req_i [NHARTS],
    input  obi_req_t                  core_data_req_i  [NHARTS],
    output obi_req_t                  voted_core_instr_req_o,
    output obi_req_t                  voted_core_data_req_o,
    input  logic                      enable_i,
    input  logic                      clear_i,
    output logic                      error_o,
    output logic [NHARTS-1:0]         error_id_o,
    output logic [NHARTS-1:0]         faulty_o,
    output logic [1:0]                state_o,
    output logic                      fail_o,
    output logic [NHARTS*CNT_W-1:0]   err_cnt_o
);

    localparam int unsigned W   = $bits(obi_req_t);
    localparam logic [7:0]  THR = 8'(ERR_THRESHOLD);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_VOTE = 2'd1,
        ST_DEGR = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    function automatic logic [W-1:0] vote_f(input obi_req_t reqs [NHARTS]);
        logic [W-1:0] v;
        int unsigned  cnt;
        v = '0;
        for (int b = 0; b < W; b++) begin
            cnt = 32'd0;
            for (int h = 0; h < NHARTS; h++) begin
                cnt = cnt + {31'd0, reqs[h][b]};
            end
            v[b] = (cnt > (NHARTS / 32'd2));
        end
        return v;
    endfunction

    // addr only matters when the hart requests, wdata only when it writes
    function automatic logic chan_mis_f(input obi_req_t h, input obi_req_t v);
        return ((h.addr != v.addr) && h.req) || ((h.wdata != v.wdata) && h.we) ||
               (h.be != v.be) || (h.we != v.we) || (h.req != v.req);
    endfunction

    function automatic int unsigned popcnt_f(input logic [NHARTS-1:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < NHARTS; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    obi_req_t          instr_vote_s, data_vote_s;
    logic [NHARTS-1:0] mis_s;
    logic              any_req_s;
    logic [7:0]        consec_q [NHARTS];
    logic [7:0]        consec_d [NHARTS];
    logic [NHARTS-1:0] faulty_q, faulty_d;
    int unsigned       healthy_s;
    state_e            state_q, state_d;
    logic              fail_q, error_q;
    logic [NHARTS-1:0] error_id_q;

    // Bitwise majority vote of both channels
    always_comb begin
        instr_vote_s = vote_f(core_instr_req_i);
        data_vote_s  = vote_f(core_data_req_i);
    end

    // Qualified per-hart mismatch against the voted result
    always_comb begin
        any_req_s = instr_vote_s.req | data_vote_s.req;
        mis_s     = '0;
        for (int i = 0; i < NHARTS; i++) begin
            mis_s[i] = enable_i &
                ((instr_vote_s.req & chan_mis_f(core_instr_req_i[i], instr_vote_s)) |
                 (data_vote_s.req  & chan_mis_f(core_data_req_i[i],  data_vote_s)));
        end
    end

    // Consecutive-mismatch counters and sticky faulty mask update
    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            consec_d[i] = consec_q[i];
            faulty_d[i] = faulty_q[i];
            if (clear_i) begin
                consec_d[i] = 8'd0;
                faulty_d[i] = 1'b0;
            end else begin
                if (state_q == ST_OFF) begin
                    consec_d[i] = 8'd0;
                end else if (mis_s[i]) begin
                    consec_d[i] = (consec_q[i] >= THR) ? THR : consec_q[i] + 8'd1;
                end else if (any_req_s) begin
                    consec_d[i] = 8'd0;
                end else begin
                    consec_d[i] = consec_q[i];
                end
                faulty_d[i] = faulty_q[i] | (consec_d[i] == THR);
            end
        end
        healthy_s = NHARTS - popcnt_f(faulty_d);
    end

    // Next-state logic, evaluated on the post-update faulty mask so state tracks faulty_o
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_OFF;
        end else if (clear_i) begin
            state_d = ST_VOTE;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (healthy_s == NHARTS)               state_d = ST_VOTE;
                    else if (healthy_s > (NHARTS / 32'd2)) state_d = ST_DEGR;
                    else                                   state_d = ST_FAIL;
                end
                ST_VOTE: begin
                    if (healthy_s <= (NHARTS / 32'd2)) state_d = ST_FAIL;
                    else if (healthy_s < NHARTS)       state_d = ST_DEGR;
                    else                               state_d = ST_VOTE;
                end
                ST_DEGR: begin
                    if (healthy_s <= (NHARTS / 32'd2)) state_d = ST_FAIL;
                    else                               state_d = ST_DEGR;
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_OFF;
            endcase
        end
    end

    // State register plus registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_OFF;
            fail_q     <= 1'b0;
            faulty_q   <= '0;
            error_q    <= 1'b0;
            error_id_q <= '0;
        end else begin
            state_q    <= state_d;
            fail_q     <= (state_d == ST_FAIL);
            faulty_q   <= faulty_d;
            error_q    <= |(mis_s & ~faulty_q);
            error_id_q <= mis_s;
        end
    end

    // Consecutive-mismatch counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NHARTS; i++) consec_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NHARTS; i++) consec_q[i] <= consec_d[i];
        end
    end

    // Output drive; bus requests are suppressed once the system has failed
    always_comb begin
        voted_core_instr_req_o = instr_vote_s;
        voted_core_data_req_o  = data_vote_s;
        if (state_q == ST_FAIL) begin
            voted_core_instr_req_o.req = 1'b0;
            voted_core_data_req_o.req  = 1'b0;
        end else begin
            voted_core_instr_req_o.req = instr_vote_s.req;
            voted_core_data_req_o.req  = data_vote_s.req;
        end
        state_o    = state_q;
        fail_o     = fail_q;
        faulty_o   = faulty_q;
        error_o    = error_q;
        error_id_o = error_id_q;
    end

`ifdef TMR_VOTER_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q [NHARTS];
    logic [CNT_W-1:0] err_cnt_d [NHARTS];

    // Saturating total error counters
    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            if (clear_i) begin
                err_cnt_d[i] = '0;
            end else if (mis_s[i] && (err_cnt_q[i] != {CNT_W{1'b1}})) begin
                err_cnt_d[i] = err_cnt_q[i] + CNT_W'(1);
            end else begin
                err_cnt_d[i] = err_cnt_q[i];
            end
        end
    end

    // Error counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NHARTS; i++) err_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NHARTS; i++) err_cnt_q[i] <= err_cnt_d[i];
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        err_cnt_o = '0;
        for (int i = 0; i < NHARTS; i++) err_cnt_o[i*CNT_W +: CNT_W] = err_cnt_q[i];
    end
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tmr_voter_seq.sv
// Scoreboard bench for tmr_voter_seq (NHARTS=3, ERR_THRESHOLD=4, CNT_W=2); works with or without TMR_VOTER_ERR_CNT_EN.
module tb_tmr_voter_seq;
    import tmr_voter_pkg::*;

    typedef struct {
        logic       err;
        logic [2:0] id;
        logic [2:0] faulty;
        logic [1:0] st;
        logic       fail;
        logic [5:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    obi_req_t   instr_req [3];
    obi_req_t   data_req  [3];
    obi_req_t   v_instr, v_data;
    logic       enable, clear;
    logic       error_o, fail_o;
    logic [2:0] error_id_o, faulty_o;
    logic [1:0] state_o;
    logic [5:0] err_cnt_o;

    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       sb_q [$];

    int         m_consec [3];
    int         m_cnt    [3];
    logic [2:0] m_faulty;
    logic [1:0] m_state;

    tmr_voter_seq #(.NHARTS(3), .ERR_THRESHOLD(4), .CNT_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_instr_req_i(instr_req), .core_data_req_i(data_req),
        .voted_core_instr_req_o(v_instr), .voted_core_data_req_o(v_data),
        .enable_i(enable), .clear_i(clear),
        .error_o(error_o), .error_id_o(error_id_o), .faulty_o(faulty_o),
        .state_o(state_o), .fail_o(fail_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic obi_req_t maj3(input obi_req_t a, input obi_req_t b, input obi_req_t c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    function automatic logic ch_mis(input obi_req_t h, input obi_req_t v);
        return ((h.addr != v.addr) && h.req) || ((h.wdata != v.wdata) && h.we) ||
               (h.be != v.be) || (h.we != v.we) || (h.req != v.req);
    endfunction

    task automatic set_all(input logic [31:0] ia, input logic ireq, input logic [31:0] da, input logic dreq);
        for (int h = 0; h < 3; h++) begin
            instr_req[h] = '{req: ireq, we: 1'b0, be: 4'hf, addr: ia, wdata: 32'h0};
            data_req[h]  = '{req: dreq, we: 1'b0, be: 4'hf, addr: da, wdata: 32'hcafe0000};
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < 3; h++) begin
            m_consec[h] = 0;
            m_cnt[h]    = 0;
        end
        m_faulty = 3'b000;
        m_state  = 2'd0;
        sb_q.delete();
    endtask

    // One clock: check the combinational vote, predict and check the registered outputs
    task automatic step();
        obi_req_t   vi, vd, ei, ed;
        logic [2:0] mis, nf;
        int         nc [3];
        int         ncnt [3];
        int         hl;
        logic [1:0] ns;
        logic       anyr;
        exp_t       e, g;
        #1;
        vi = maj3(instr_req[0], instr_req[1], instr_req[2]);
        vd = maj3(data_req[0], data_req[1], data_req[2]);
        ei = vi;
        ed = vd;
        if (m_state == 2'd3) begin
            ei.req = 1'b0;
            ed.req = 1'b0;
        end
        chk("voted_instr", v_instr, ei);
        chk("voted_data", v_data, ed);
        anyr = vi.req | vd.req;
        for (int h = 0; h < 3; h++) begin
            mis[h] = enable & ((vi.req & ch_mis(instr_req[h], vi)) | (vd.req & ch_mis(data_req[h], vd)));
        end
        for (int h = 0; h < 3; h++) begin
            if (clear)                nc[h] = 0;
            else if (m_state == 2'd0) nc[h] = 0;
            else if (mis[h])          nc[h] = (m_consec[h] >= 4) ? 4 : m_consec[h] + 1;
            else if (anyr)            nc[h] = 0;
            else                      nc[h] = m_consec[h];
            nf[h] = clear ? 1'b0 : (m_faulty[h] | (nc[h] == 4));
`ifdef TMR_VOTER_ERR_CNT_EN
            ncnt[h] = clear ? 0 : ((mis[h] && m_cnt[h] < 3) ? m_cnt[h] + 1 : m_cnt[h]);
`else
            ncnt[h] = 0;
`endif
        end
        hl = 3 - $countones(nf);
        if (!enable)           ns = 2'd0;
        else if (clear)        ns = 2'd1;
        else if (m_state == 2'd3) ns = 2'd3;
        else if (hl <= 1)      ns = 2'd3;
        else if (hl == 2)      ns = 2'd2;
        else                   ns = (m_state == 2'd2) ? 2'd2 : 2'd1;
        e.err    = |(mis & ~m_faulty);
        e.id     = mis;
        e.faulty = nf;
        e.st     = ns;
        e.fail   = (ns == 2'd3);
        e.cnt    = {2'(ncnt[2]), 2'(ncnt[1]), 2'(ncnt[0])};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk("error_o", error_o, g.err);
        chk("error_id_o", error_id_o, g.id);
        chk("faulty_o", faulty_o, g.faulty);
        chk("state_o", state_o, g.st);
        chk("fail_o", fail_o, g.fail);
        chk("err_cnt_o", err_cnt_o, g.cnt);
        for (int h = 0; h < 3; h++) begin
            m_consec[h] = nc[h];
            m_cnt[h]    = ncnt[h];
        end
        m_faulty = nf;
        m_state  = ns;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_error"}, error_o, 1'b0);
        chk({tag, "_id"}, error_id_o, 3'b000);
        chk({tag, "_faulty"}, faulty_o, 3'b000);
        chk({tag, "_state"}, state_o, 2'd0);
        chk({tag, "_fail"}, fail_o, 1'b0);
        chk({tag, "_cnt"}, err_cnt_o, 6'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        set_all(32'h0, 1'b0, 32'h0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals("rst");
        rst_ni = 1'b1;
        @(negedge clk);

        // identical requests
        set_all(32'h1000, 1'b1, 32'h2000, 1'b0);
        enable = 1'b1;
        step();
        chk("vote_state", state_o, 2'd1);
        chk("vote_noerr", error_o, 1'b0);
        chk("vote_addr", v_instr.addr, 32'h1000);
        step();

        // single-cycle data mismatch on hart 1
        set_all(32'h1000, 1'b1, 32'h2000, 1'b1);
        data_req[1].addr = 32'h2004;
        step();
        chk("d_vaddr", v_data.addr, 32'h2000);
        chk("d_err", error_o, 1'b1);
        chk("d_id", error_id_o, 3'b010);
        data_req[1].addr = 32'h2000;
        step();
        chk("d_clr_err", error_o, 1'b0);

        // hart 2 reaches threshold
        instr_req[2].addr = 32'h1234;
        repeat (4) step();
        chk("h2_faulty", faulty_o, 3'b100);
        chk("h2_state", state_o, 2'd2);
        step();
        chk("h2_id", error_id_o, 3'b100);
        chk("h2_noerr", error_o, 1'b0);

        // hart 0 also fails -> FAIL
        instr_req[0].addr = 32'h1001;
        repeat (4) step();
        chk("fail_state", state_o, 2'd3);
        chk("fail_o", fail_o, 1'b1);
        chk("fail_ireq", v_instr.req, 1'b0);
        chk("fail_dreq", v_data.req, 1'b0);
        chk("fail_addr", v_instr.addr, 32'h1000);

        // clear wins over ongoing mismatches
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_faulty", faulty_o, 3'b000);
        chk("clr_state", state_o, 2'd1);
        set_all(32'h1000, 1'b1, 32'h2000, 1'b1);
        step();

        // two harts fail together: VOTE -> FAIL directly
        instr_req[0].addr = 32'h1111;
        instr_req[2].addr = 32'h2222;
        repeat (3) step();
        chk("dual_pre", state_o, 2'd1);
        step();
        chk("dual_faulty", faulty_o, 3'b101);
        chk("dual_state", state_o, 2'd3);

        set_all(32'h1000, 1'b1, 32'h2000, 1'b1);
        enable = 1'b0;
        step();
        chk("off_state", state_o, 2'd0);
        enable = 1'b1;
        clear  = 1'b1;
        step();
        clear = 1'b0;
        chk("reen_state", state_o, 2'd1);

        // error counter saturation on hart 1
        data_req[1].we = 1'b1;
        repeat (5) step();
`ifdef TMR_VOTER_ERR_CNT_EN
        chk("cnt_sat", err_cnt_o[3:2], 2'd3);
`else
        chk("cnt_tied", err_cnt_o, 6'd0);
`endif
        clear = 1'b1;
        step();
        clear = 1'b0;

        // random perturbations
        for (int r = 0; r < 80; r++) begin
            set_all(32'h1000, 1'($urandom_range(0, 3) != 0), 32'h2000, 1'($urandom_range(0, 1)));
            for (int h = 0; h < 3; h++) begin
                if ($urandom_range(0, 3) == 0) begin
                    int idx;
                    idx = $urandom_range(0, 31);
                    instr_req[h].addr[idx] = ~instr_req[h].addr[idx];
                end
                if ($urandom_range(0, 5) == 0) data_req[h].we = 1'b1;
                if ($urandom_range(0, 7) == 0) data_req[h].be = 4'h3;
            end
            clear  = ($urandom_range(0, 15) == 0);
            enable = ($urandom_range(0, 19) != 0);
            step();
        end
        clear  = 1'b0;
        enable = 1'b1;

        // asynchronous reset mid-operation
        set_all(32'h1000, 1'b1, 32'h2000, 1'b1);
        instr_req[1].addr = 32'h1800;
        repeat (4) step();
        #3;
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("arst");
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        set_all(32'h1000, 1'b1, 32'h2000, 1'b1);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tmr_voter_seq.md
# tmr_voter_seq

Parametrised, stateful successor to the combinational OBI triple-modular-redundancy voter. Sits between NHARTS redundant cores and the system bus. Bitwise-majority-votes the instruction and data OBI requests with zero latency, and adds registered error reporting, per-hart consecutive-mismatch tracking, sticky faulty-hart isolation, a degrade/fail state machine, and optional per-hart error counters.

## Interface
- NHARTS, 3: redundant harts; odd, 3 or 5.
- ERR_THRESHOLD, 4: consecutive mismatching cycles that mark a hart faulty; 1..255.
- CNT_W, 8: width of each per-hart total error counter.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- core_instr_req_i  in  obi_req_t[NHARTS]  per-hart instruction requests.
- core_data_req_i  in  obi_req_t[NHARTS]  per-hart data requests.
- voted_core_instr_req_o  out  obi_req_t  voted instruction request.
- voted_core_data_req_o  out  obi_req_t  voted data request.
- enable_i  in  1  checking enable.
- clear_i  in  1  synchronous clear of faulty mask and all counters.
- error_o  out  1  registered error pulse: non-faulty hart mismatched.
- error_id_o  out  NHARTS  registered per-hart mismatch flags.
- faulty_o  out  NHARTS  sticky faulty-hart mask.
- state_o  out  2  FSM state: 0 OFF, 1 VOTE, 2 DEGRADED, 3 FAIL.
- fail_o  out  1  high in FAIL.
- err_cnt_o  out  NHARTS*CNT_W  per-hart saturating error counts, hart i at [i*CNT_W +: CNT_W].

## Operation
- Voting: each bit of addr, wdata, we, be, req is set when more than NHARTS/2 harts have it set. Purely combinational.
- Per-hart, per-channel mismatch: (addr differs and hart req) or (wdata differs and hart we) or be, we or req differs.
- A mismatch is qualified only when enable_i=1 and that channel's voted req=1.
- mis[i] = qualified instr mismatch | qualified data mismatch.
- consec[i] is an 8-bit counter.
  - On mis[i]: increments, saturating at ERR_THRESHOLD.
  - On a cycle with a voted req on either channel and no mis[i]: clears to 0.
  - On cycles with no voted req: holds.
- faulty[i] sets on the edge where consec[i] reaches ERR_THRESHOLD. It is sticky until clear_i or reset.
- Healthy count H = NHARTS - popcount(faulty).
- FSM:
  - OFF -> VOTE/DEGRADED/FAIL when enable_i=1, chosen by H.
  - Any state -> OFF when enable_i=0.
  - VOTE -> DEGRADED when 0 < popcount(faulty) and H > NHARTS/2.
  - VOTE or DEGRADED -> FAIL when H ≤ NHARTS/2. Direct VOTE -> FAIL is allowed.
  - FAIL exits only via clear_i, reset or enable_i=0.
- In OFF, consec counters clear; faulty mask and err_cnt hold.
- error_o = registered OR of mis[i] over non-faulty harts. error_id_o = registered mis (all harts, faulty ones included).
- In FAIL, voted_core_instr_req_o.req and voted_core_data_req_o.req are forced to 0. All other fields stay voted.
- clear_i wins over simultaneous mismatches. Next cycle: consec, faulty and err_cnt are 0, and state is VOTE (or OFF if enable_i=0).

## Timing
- Reset values: error_o=0, error_id_o=0, faulty_o=0, state_o=OFF, fail_o=0, err_cnt_o=0, all consec=0.
- Voted outputs: 0-cycle latency; combinational from inputs plus the FSM register in FAIL.
- error_o and error_id_o: 1-cycle latency from the mismatching cycle.
- faulty_o: set 1 cycle after the ERR_THRESHOLD-th consecutive mismatch cycle.
- state_o and fail_o: update on the same edge as faulty_o.
- Two harts reaching threshold on the same edge are both marked, and the FSM moves once to the resulting state.
- Asynchronous reset mid-operation returns everything to reset values immediately. The voted request is gated only while state is FAIL.

## Configuration
- TMR_VOTER_ERR_CNT_EN defined:
  - Per-hart CNT_W-bit total error counters are instantiated.
  - Each increments on every mis[i] cycle, saturates at all-ones, and clears on clear_i.
- Not defined:
  - No counter flops.
  - err_cnt_o is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then enable_i=1 with identical requests (req=1, addr=0x1000) on all harts -> voted addr 0x1000, error_o=0, state_o=1 from the cycle after enable.
- Hart 1 data addr=0x2004 for 1 cycle, others 0x2000, voted data req=1 -> voted addr 0x2000, error_o=1 and error_id_o=3'b010 one cycle later; consec[1] returns to 0 after a matching cycle.
- Hart 2 mismatches 4 consecutive voted-req cycles (ERR_THRESHOLD=4) -> faulty_o=3'b100, state_o=2 after the 4th edge; further hart-2 mismatches give error_id_o[2]=1, error_o=0.
- From DEGRADED, hart 0 mismatches 4 cycles -> state_o=3, fail_o=1, both voted req outputs 0 while addr is still voted; clear_i=1 -> faulty_o=0, state_o=1.
- Harts 0 and 2 both mismatch 4 cycles together from VOTE -> faulty_o=3'b101, state_o goes 1 -> 3 directly.
- With TMR_VOTER_ERR_CNT_EN and CNT_W=2, hart 1 mismatches 5 cycles -> err_cnt hart 1 saturates at 3; without the macro, err_cnt_o=0.
